fp_std_arbiter: RTL and testbench

- Shares one `standardizer` instance (normalize + round) between two requesters: the adder/subtractor path (src 0) and the multiplier path (src 1).
- Accepts raw {sign, exp, 26-bit mantissa, operator, loss} results from each path over valid/ready handshakes.
- Grants one request at a time using round-robin.
- Registers the operands in front of the standardizer, captures its output, and presents a tagged, packed IEEE-754 single result downstream with backpressure.

---
 rtl/fp_std_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_fp_std_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_std_arbiter.sv
// Round-robin arbiter sharing one standardizer (normalize + round) between the add/sub path (src 0)
// and the multiplier path (src 1). Define FP_STD_ARB_STATS_EN to add saturating grant counters.

// Mantissa layout: bit 25 is carry-out, bit 24 the hidden one, bits 23:1 fraction, bit 0 guard.
// Rounding is nearest-even. On the subtract path (operator=1) a set loss bit means the exact value
// lies just below the kept bits, so it can only pull a tie down, never push it up.
// Exponent arithmetic wraps modulo 256; range checking is left to the requesters.
module standardizer (
  input  logic [7:0]  i_exp,
  input  logic [25:0] i_mantis,
  input  logic        i_operator,
  input  logic        i_loss,
  output logic [7:0]  o_exp,
  output logic [22:0] o_mantis
);
  logic [4:0]  w_lz;
  logic [24:0] w_norm;
  logic [7:0]  w_exp_norm;
  logic        w_sticky;
  logic        w_inc;
  logic [24:0] w_sum;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_lz       = 5'd0;
    w_norm     = i_mantis[24:0];
    w_sticky   = 1'b0;
    w_exp_norm = i_exp;
    for (int i = 0; i <= 24; i++) begin
      if (i_mantis[i]) w_lz = 5'(24 - i);
    end
    if (i_mantis[25]) begin
      w_norm     = i_mantis[25:1];
      w_sticky   = i_mantis[0];
      w_exp_norm = i_exp + 8'd1;
    end else if (i_mantis != 26'd0) begin
      w_norm     = i_mantis[24:0] << w_lz;
      w_exp_norm = i_exp - 8'(w_lz);
    end
    w_inc = w_norm[0] & (w_sticky | (i_loss & ~i_operator) | (w_norm[1] & ~(i_loss & i_operator)));
    w_sum = {1'b0, w_norm[24:1]} + 25'(w_inc);
    // A carry out of the hidden bit leaves an all-zero fraction and bumps the exponent.
    o_mantis = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    o_exp    = w_exp_norm + 8'(w_sum[24]);
  end
endmodule

module fp_std_arbiter #(
  parameter int RR_INIT = 0,
  parameter int STAT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_sign,
  input  logic [7:0]  req0_exp,
  input  logic [25:0] req0_mantis,
  input  logic        req0_operator,
  input  logic        req0_loss,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_sign,
  input  logic [7:0]  req1_exp,
  input  logic [25:0] req1_mantis,
  input  logic        req1_operator,
  input  logic        req1_loss,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_sign,
  output logic [7:0]  res_exp,
  output logic [22:0] res_mantis,
  output logic        res_src,
  output logic        busy
`ifdef FP_STD_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_HOLD} state_t;

  if (!(RR_INIT inside {0, 1}) || STAT_W < 1) begin : g_param_check
    $error("fp_std_arbiter: RR_INIT must be 0 or 1 and STAT_W at least 1");
  end

  state_t      r_state, w_state_nxt;
  logic        r_ptr;
  logic        r_op_sign, r_op_operator, r_op_loss, r_op_src;
  logic [7:0]  r_op_exp;
  logic [25:0] r_op_mantis;
  logic        r_res_valid, r_res_sign, r_res_src;
  logic [7:0]  r_res_exp;
  logic [22:0] r_res_mantis;
  logic        w_gnt0, w_gnt1, w_take, w_capture;
  logic [7:0]  w_std_exp;
  logic [22:0] w_std_mantis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_gnt0      = req0_valid & (~req1_valid | ~r_ptr);
    w_gnt1      = req1_valid & (~req0_valid | r_ptr);
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_capture   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Held low while rst is high so the async reset silences the handshake immediately.
        req0_ready = w_gnt0 & ~rst;
        req1_ready = w_gnt1 & ~rst;
        if (w_gnt0 | w_gnt1) w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_take = req0_ready | req1_ready;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= 1'(RR_INIT);
      r_op_sign     <= 1'b0;
      r_op_operator <= 1'b0;
      r_op_loss     <= 1'b0;
      r_op_src      <= 1'b0;
      r_op_exp      <= 8'd0;
      r_op_mantis   <= 26'd0;
      r_res_valid   <= 1'b0;
      r_res_sign    <= 1'b0;
      r_res_src     <= 1'b0;
      r_res_exp     <= 8'd0;
      r_res_mantis  <= 23'd0;
    end else begin
      if (w_take) begin
        r_op_sign     <= w_gnt1 ? req1_sign     : req0_sign;
        r_op_operator <= w_gnt1 ? req1_operator : req0_operator;
        r_op_loss     <= w_gnt1 ? req1_loss     : req0_loss;
        r_op_exp      <= w_gnt1 ? req1_exp      : req0_exp;
        r_op_mantis   <= w_gnt1 ? req1_mantis   : req0_mantis;
        r_op_src      <= w_gnt1;
        r_ptr         <= ~w_gnt1;
      end
      if (w_capture) begin
        r_res_valid  <= 1'b1;
        r_res_sign   <= r_op_sign;
        r_res_src    <= r_op_src;
        r_res_exp    <= w_std_exp;
        r_res_mantis <= w_std_mantis;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  standardizer u_std (
    .i_exp      (r_op_exp),
    .i_mantis   (r_op_mantis),
    .i_operator (r_op_operator),
    .i_loss     (r_op_loss),
    .o_exp      (w_std_exp),
    .o_mantis   (w_std_mantis)
  );

  assign res_valid  = r_res_valid;
  assign res_sign   = r_res_sign;
  assign res_src    = r_res_src;
  assign res_exp    = r_res_exp;
  assign res_mantis = r_res_mantis;

`ifdef FP_STD_ARB_STATS_EN
  logic [STAT_W-1:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready && !(&r_cnt0)) r_cnt0 <= r_cnt0 + STAT_W'(1);
      if (req1_ready && !(&r_cnt1)) r_cnt1 <= r_cnt1 + STAT_W'(1);
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_fp_std_arbiter.sv
// Randomized self-checking bench for fp_std_arbiter against a transaction-level model;
// grant-counter checks are compiled in when FP_STD_ARB_STATS_EN is defined.
module tb_fp_std_arbiter;
  localparam int RR_INIT = 0;
  localparam int STAT_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic        req0_valid = 1'b0, req0_sign = 1'b0, req0_operator = 1'b0, req0_loss = 1'b0;
  logic [7:0]  req0_exp = '0;
  logic [25:0] req0_mantis = '0;
  logic        req1_valid = 1'b0, req1_sign = 1'b0, req1_operator = 1'b0, req1_loss = 1'b0;
  logic [7:0]  req1_exp = '0;
  logic [25:0] req1_mantis = '0;
  logic        res_ready = 1'b0;
  logic        req0_ready, req1_ready, res_valid, res_sign, res_src, busy;
  logic [7:0]  res_exp;
  logic [22:0] res_mantis;
`ifdef FP_STD_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  fp_std_arbiter #(.RR_INIT(RR_INIT), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sign(req0_sign), .req0_exp(req0_exp),
    .req0_mantis(req0_mantis), .req0_operator(req0_operator), .req0_loss(req0_loss),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sign(req1_sign), .req1_exp(req1_exp),
    .req1_mantis(req1_mantis), .req1_operator(req1_operator), .req1_loss(req1_loss),
    .res_valid(res_valid), .res_ready(res_ready), .res_sign(res_sign), .res_exp(res_exp),
    .res_mantis(res_mantis), .res_src(res_src), .busy(busy)
`ifdef FP_STD_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Value-level model of the standardizer: scale the mantissa into a wide integer, normalize by
  // doubling/halving, then round the kept 24 bits to nearest-even using the remainder in eighths.
  function automatic void std_model(input logic [7:0] e_in, input logic [25:0] m, input logic op,
                                    input logic loss, output logic [7:0] e_out, output logic [22:0] f_out);
    longint v, t, r;
    int e;
    bit up;
    e_out = e_in;
    f_out = '0;
    if (m == 26'd0) return;
    v = longint'(m) * 4;
    e = int'(e_in);
    while (v >= 134217728) begin v = v / 2; e++; end
    while (v < 67108864)   begin v = v * 2; e--; end
    t  = v / 8;
    r  = v % 8;
    up = (r > 4) || (r == 4 && !(op && loss) && (loss || (t % 2) == 1));
    if (up) t++;
    if (t == 16777216) begin t = 8388608; e++; end
    e_out = 8'(e);
    f_out = 23'(t - 8388608);
  endfunction

  // Transaction model: a request is "working" for the cycle after its grant, then "offered"
  // until downstream takes it; new grants only happen when neither is true.
  bit          m_working, m_offer, m_ptr;
  logic        m_sign, m_src;
  logic [7:0]  m_exp;
  logic [22:0] m_frac;
  int          m_cnt0, m_cnt1;
  int          cycle = 0;
  int          grant_src[$];
  int          grant_cyc[$];

  task automatic model_reset();
    m_working = 0;
    m_offer   = 0;
    m_ptr     = 1'(RR_INIT);
    m_cnt0    = 0;
    m_cnt1    = 0;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_req0_ready"}, req0_ready, 0);
    check({pfx, "_req1_ready"}, req1_ready, 0);
    check({pfx, "_res_valid"}, res_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_res_sign"}, res_sign, 0);
    check({pfx, "_res_exp"}, res_exp, 0);
    check({pfx, "_res_mantis"}, res_mantis, 0);
    check({pfx, "_res_src"}, res_src, 0);
`ifdef FP_STD_ARB_STATS_EN
    check({pfx, "_cnt0"}, grant_cnt0, 0);
    check({pfx, "_cnt1"}, grant_cnt1, 0);
`endif
  endtask

  // Called at a negedge: asserts rst asynchronously, checks outputs, releases at the next negedge.
  task automatic do_reset(input string pfx);
    req0_valid = 1;
    req1_valid = 1;
    rst = 1;
    #1;
    check_quiet(pfx);
    model_reset();
    @(negedge clk);
    rst = 0;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  // One clock cycle: inputs are already driven; check handshakes, advance, check results.
  task automatic tick();
    bit e0, e1;
    int cmax;
    #1;
    e0 = !m_working && !m_offer && req0_valid && (!req1_valid || !m_ptr);
    e1 = !m_working && !m_offer && req1_valid && (!req0_valid || m_ptr);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    @(posedge clk);
    cycle++;
    if (m_working) begin
      m_working = 0;
      m_offer   = 1;
    end else if (m_offer) begin
      if (res_ready) m_offer = 0;
    end else if (e0 || e1) begin
      if (e1) std_model(req1_exp, req1_mantis, req1_operator, req1_loss, m_exp, m_frac);
      else    std_model(req0_exp, req0_mantis, req0_operator, req0_loss, m_exp, m_frac);
      m_sign    = e1 ? req1_sign : req0_sign;
      m_src     = e1;
      m_ptr     = !e1;
      m_working = 1;
      grant_src.push_back(int'(e1));
      grant_cyc.push_back(cycle);
      cmax = (1 << STAT_W) - 1;
      if (e1) m_cnt1 = (m_cnt1 < cmax) ? m_cnt1 + 1 : cmax;
      else    m_cnt0 = (m_cnt0 < cmax) ? m_cnt0 + 1 : cmax;
    end
    @(negedge clk);
    check("res_valid", res_valid, m_offer);
    check("busy", busy, m_working || m_offer);
    if (m_offer) begin
      check("res_sign", res_sign, m_sign);
      check("res_exp", res_exp, m_exp);
      check("res_mantis", res_mantis, m_frac);
      check("res_src", res_src, m_src);
    end
`ifdef FP_STD_ARB_STATS_EN
    check("grant_cnt0", grant_cnt0, m_cnt0);
    check("grant_cnt1", grant_cnt1, m_cnt1);
`endif
  endtask

  function automatic logic [25:0] rand_mantis();
    int k;
    k = $urandom_range(0, 28);
    if (k == 27) return 26'h1FFFFFF;
    if (k == 28) return 26'h3FFFFFF;
    return 26'($urandom) >> k;
  endfunction

  task automatic rand_data();
    req0_sign = 1'($urandom); req0_exp = 8'($urandom); req0_mantis = rand_mantis();
    req0_operator = 1'($urandom); req0_loss = 1'($urandom);
    req1_sign = 1'($urandom); req1_exp = 8'($urandom); req1_mantis = rand_mantis();
    req1_operator = 1'($urandom); req1_loss = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    req0_valid = 0;
    req1_valid = 0;
    res_ready  = 1;
    n = 0;
    while ((m_working || m_offer) && n < 10) begin tick(); n++; end
    check("drain_done", int'(m_working || m_offer), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    int cc;
    logic [7:0]  held_exp, e_chk;
    logic [22:0] held_mantis, f_chk;
    logic        held_src;
    logic [25:0] m_a;

    #2;
    do_reset("reset");

    // Single src0 request: ready pulses once, result appears after the next edge.
    req0_sign = 0; req0_exp = 8'h80; req0_mantis = 26'h1000000; req0_operator = 0; req0_loss = 0;
    req0_valid = 1; res_ready = 1;
    tick();
    check("t1_valid_after_grant", res_valid, 0);
    req0_valid = 0;
    tick();
    check("t1_valid_latency", res_valid, 1);
    check("t1_src", res_src, 0);
    check("t1_exp", res_exp, 8'h80);
    check("t1_mantis", res_mantis, 0);
    drain();

    // Both valid continuously from reset: alternating grants three cycles apart.
    do_reset("reset2");
    base = grant_src.size();
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    n = 0;
    while (grant_src.size() - base < 6 && n < 40) begin rand_data(); tick(); n++; end
    check("t2_grants", grant_src.size() - base, 6);
    for (int i = 0; i < 6 && base + i < grant_src.size(); i++) begin
      check("t2_src_seq", grant_src[base + i], (i + RR_INIT) % 2);
      if (i > 0) check("t2_spacing", grant_cyc[base + i] - grant_cyc[base + i - 1], 3);
    end
    drain();

    // Backpressure: result frozen, no new grant, completion then a grant one cycle later.
    rand_data();
    req0_valid = 1; res_ready = 0;
    tick();
    req1_valid = 1;
    tick();
    held_exp = res_exp; held_mantis = res_mantis; held_src = res_src;
    repeat (5) begin
      tick();
      check("t3_hold_exp", res_exp, held_exp);
      check("t3_hold_mantis", res_mantis, held_mantis);
      check("t3_hold_src", res_src, held_src);
    end
    res_ready = 1;
    tick();
    cc = cycle;
    check("t3_released", res_valid, 0);
    tick();
    check("t3_next_grant_cycle", grant_cyc[$], cc + 1);
    check("t3_next_grant_src", grant_src[$], 1);
    drain();

    // Async reset with src1 in EVAL: everything clears, nothing comes out afterwards.
    rand_data();
    req1_valid = 1; res_ready = 1;
    tick();
    req1_valid = 0;
    do_reset("t4_eval_rst");
    repeat (4) tick();
    // Reset during HOLD of a src0 result, when the pointer had moved to src1.
    req0_valid = 1; res_ready = 0;
    tick();
    req0_valid = 0;
    tick();
    do_reset("t4_hold_rst");
    repeat (3) tick();
    req0_valid = 1; req1_valid = 1;
    tick();
    check("t4_ptr_after_rst", grant_src[$], RR_INIT);
    drain();

    // Operands change right after the grant edge; the result uses the latched ones.
    req0_sign = 1; req0_exp = 8'h7F; m_a = 26'h0ABCDEF; req0_mantis = m_a;
    req0_operator = 0; req0_loss = 1;
    req0_valid = 1; res_ready = 1;
    tick();
    req0_valid = 0; req0_mantis = ~m_a; req0_exp = 8'h01; req0_sign = 0;
    tick();
    std_model(8'h7F, m_a, 1'b0, 1'b1, e_chk, f_chk);
    check("t5_latched_exp", res_exp, e_chk);
    check("t5_latched_mantis", res_mantis, f_chk);
    check("t5_latched_sign", res_sign, 1);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      res_ready  = ($urandom_range(0, 99) < 70);
      tick();
    end
    drain();

`ifdef FP_STD_ARB_STATS_EN
    begin
      int exp_cnt[5] = '{1, 2, 3, 3, 3};
      do_reset("t6_rst");
      res_ready = 1;
      for (int k = 0; k < 5; k++) begin
        base = grant_src.size();
        req1_valid = 1;
        rand_data();
        n = 0;
        while (grant_src.size() == base && n < 10) begin tick(); n++; end
        req1_valid = 0;
        check("t6_cnt1", grant_cnt1, exp_cnt[k]);
        check("t6_cnt0", grant_cnt0, 0);
        drain();
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
